// File: rtl/imm_extend_unit.sv
// Immediate extender (sign / zero / upper / branch-offset) feeding a small
// result FIFO with ready/valid handshakes on both sides.
module imm_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  word_in,
    input  logic [1:0]       mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] extend_word,
    output logic [LVL_W-1:0] level
);
    localparam int PAD = OUT_W - IN_W;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [OUT_W-1:0] sext_word, ext_word;
    logic             push, pop;

    always_comb begin
        sext_word = {{PAD{word_in[IN_W-1]}}, word_in};
        ext_word  = '0;
        unique case (mode)
            2'b00:   ext_word = sext_word;
            2'b01:   ext_word = {{PAD{1'b0}}, word_in};
            2'b10:   ext_word = {word_in, {PAD{1'b0}}};
            default: ext_word = {sext_word[OUT_W-3:0], 2'b00};
        endcase
    end

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready    = (level_reg < LVL_W'(DEPTH));
    assign out_valid   = (level_reg != '0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign level       = level_reg;
    assign extend_word = out_valid ? mem[rd_ptr_reg] : '0;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Payload storage needs no reset: it is only visible while level is nonzero.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= ext_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (pop)
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            if (push && !pop)
                level_reg <= level_reg + LVL_W'(1);
            else if (pop && !push)
                level_reg <= level_reg - LVL_W'(1);
        end
    end
endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, meaning immediate input width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 32, meaning extended output width; legal only when OUT_W >= IN_W+2.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning output buffer entries; legal only when DEPTH >= 1.
REQ-004 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port in_valid, input, 1, word_in/mode carry a request.
REQ-007 Port in_ready, output, 1, block can accept a request this cycle.
REQ-008 Port word_in, input, IN_W, immediate field.
REQ-009 Port mode, input, 2, extension mode, encoded per REQ-014.
REQ-010 Port flush, input, 1, synchronous discard of all buffered and in-flight results.
REQ-011 Port out_valid, output, 1, extend_word holds a valid result.
REQ-012 Port out_ready, input, 1, consumer takes the result this cycle.
REQ-013 Port extend_word, output, OUT_W, extended result at buffer head.
REQ-014 Port level, output, clog2(DEPTH+1), current buffer occupancy.

Function
REQ-015 Mode encoding SHALL be: 00 sign-extend; 01 zero-extend; 10 upper (word_in placed in bits OUT_W-1..OUT_W-IN_W, lower bits zero); 11 branch offset (sign-extend, then shift left 2, upper bits dropped to OUT_W).
REQ-016 A request SHALL be accepted on a cycle where in_valid and in_ready are both 1; mode and word_in SHALL be sampled on that edge only.
REQ-017 in_ready SHALL equal (level < DEPTH) and SHALL NOT depend combinationally on out_ready or in_valid.
REQ-018 An accepted result SHALL appear at the tail of the buffer; out_valid SHALL rise one cycle after acceptance into an empty buffer (latency 1).
REQ-019 A result SHALL be popped on a cycle where out_valid and out_ready are both 1; extend_word and out_valid SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous push and pop SHALL leave level unchanged and preserve order; results SHALL leave in acceptance order.
REQ-021 Read/write pointers SHALL wrap from DEPTH-1 to 0; non-power-of-two DEPTH SHALL be supported.
REQ-022 When level=DEPTH, in_ready SHALL be 0 and no request SHALL be lost or overwritten.
REQ-023 When out_valid=0, extend_word SHALL drive 0.
REQ-024 flush=1 SHALL, on that edge, set level to 0, reset pointers, and discard any request accepted on the same cycle; flush SHALL take priority over push and pop.
REQ-025 out_valid SHALL be 0 in the cycle after a flush unless a new request is accepted in that later cycle, with results following REQ-018.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock, force level=0, out_valid=0, extend_word=0, in_ready=1 and pointers to 0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered results; the first request after rst_n rises SHALL be accepted on the first rising clk edge with rst_n=1.

Verification
REQ-028 Default parameters, modes 00/01/10/11 with word_in=0x8001/0x8001/0x1234/0xFFFF, out_ready=1 -> extend_word 0xFFFF8001, 0x00008001, 0x12340000, 0xFFFFFFFC, each one cycle after acceptance.
REQ-029 DEPTH=2, out_ready=0, three back-to-back requests 0x0001, 0x0002, 0x0003 in mode 01 -> in_ready low after second accept, level=2, third held; after out_ready=1, outputs 0x1, 0x2, 0x3 in order.
REQ-030 level=1, simultaneous push 0x7FFF mode 00 and pop -> level stays 1; next extend_word 0x00007FFF.
REQ-031 level=2 with flush=1 and in_valid=1 on the same cycle -> next cycle level=0, out_valid=0, extend_word=0, in_ready=1.
REQ-032 rst_n pulsed low asynchronously between edges with level=2 -> out_valid and level drop to 0 without a clock edge; post-reset request 0xFFFE mode 11 -> 0xFFFFFFF8.
REQ-033 DEPTH=3, IN_W=8, OUT_W=16, eight pushes with random out_ready -> order preserved across pointer wrap; 0x80 mode 00 yields 0xFF80.
